// File: rtl/fabric_loader_pkg.sv
// Shared types and constants for the SPI-flash bitstream loader.
// Slot base address arithmetic lives here so every user agrees on the wrap-around.
package fabric_loader_pkg;

    localparam logic [7:0] SPI_CMD_READ = 8'h03;
    localparam int         WORD_BITS    = 32;
    localparam int         NBITS_W      = $clog2(WORD_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        END
    } loader_state_t;

    // Deliberately truncated to 24 bits: slots past the top of flash wrap to low addresses.
    function automatic logic [23:0] slot_addr(input logic [23:0] base,
                                              input logic [23:0] stride,
                                              input logic [3:0]  slot);
        return base + stride * {20'h0, slot};
    endfunction

endpackage

// File: rtl/spi_shifter.sv
// Mode-0 SPI bit engine: two clk cycles per bit (sck low, then sck high), MSB first.
// One 32-bit register transmits the loaded field and collects MISO on every sck rise.
module spi_shifter
    import fabric_loader_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [NBITS_W-1:0]   nbits_i,
    input  logic [WORD_BITS-1:0] tx_i,
    input  logic                 tx_en_i,
    input  logic                 miso_i,
    output logic                 sck_o,
    output logic                 mosi_o,
    output logic [WORD_BITS-1:0] rx_word_o,
    output logic                 word_done_o,
    output logic                 bit_done_o
);

    logic [WORD_BITS-1:0] shift_q;
    logic [NBITS_W-1:0]   cnt_q;
    logic                 phase_q;
    logic                 run_q;
    logic                 sck_q;
    logic                 mosi_q;
    logic                 tx_en_q;

    // word_done: this cycle's closing edge takes the field's last sample.
    // bit_done: final cycle of the field, a new load here continues without a gap.
    always_comb begin
        word_done_o = run_q & ~phase_q & (cnt_q == NBITS_W'(1));
        bit_done_o  = run_q &  phase_q & (cnt_q == NBITS_W'(1));
        rx_word_o   = {shift_q[WORD_BITS-2:0], miso_i};
        sck_o       = sck_q;
        mosi_o      = mosi_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            run_q   <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            tx_en_q <= 1'b0;
        end else if (load_i) begin
            shift_q <= tx_i;
            cnt_q   <= nbits_i;
            phase_q <= 1'b0;
            run_q   <= 1'b1;
            sck_q   <= 1'b0;
            tx_en_q <= tx_en_i;
            mosi_q  <= tx_en_i & tx_i[WORD_BITS-1];
        end else if (run_q) begin
            if (!phase_q) begin
                sck_q   <= 1'b1;
                shift_q <= rx_word_o;
                phase_q <= 1'b1;
            end else begin
                sck_q   <= 1'b0;
                phase_q <= 1'b0;
                cnt_q   <= cnt_q - NBITS_W'(1);
                run_q   <= (cnt_q != NBITS_W'(1));
                mosi_q  <= tx_en_q & shift_q[WORD_BITS-1];
            end
        end
    end

endmodule

// File: rtl/bitstream_loader.sv
// Streams a bitstream slot from SPI NOR flash (READ 0x03) to the fabric config port.
// state | meaning
// IDLE  | cs high, waiting for boot_i or the post-reset autoboot
// CMD   | shifting out the 8-bit read command
// ADDR  | shifting out the 24-bit slot address
// DATA  | reading 32-bit words back to back, one valid strobe per word
// END   | one cycle with sck low before cs is released
module bitstream_loader
    import fabric_loader_pkg::*;
#(
    parameter logic [23:0] SLOT_BASE       = 24'h000000,
    parameter logic [23:0] SLOT_SIZE       = 24'h010000,
    parameter int          BITSTREAM_WORDS = 4096,
    parameter int          AUTOBOOT        = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        boot_i,
    input  logic [3:0]  slot_i,
    output logic [31:0] bitstream_data_o,
    output logic        bitstream_valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        spi_sck_o,
    output logic        spi_cs_no,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i
);

    localparam int WCNT_W = $clog2(BITSTREAM_WORDS + 1);

    loader_state_t        state_q, state_d;
    logic [23:0]          addr_q, addr_d;
    logic [WCNT_W-1:0]    wcnt_q, wcnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 cs_q, cs_d;
    logic [31:0]          data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 first_q;

    logic                 ld;
    logic [NBITS_W-1:0]   ld_nbits;
    logic [WORD_BITS-1:0] ld_tx;
    logic                 ld_tx_en;
    logic [WORD_BITS-1:0] rx_word;
    logic                 word_done;
    logic                 bit_done;

    spi_shifter u_shifter (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (ld),
        .nbits_i     (ld_nbits),
        .tx_i        (ld_tx),
        .tx_en_i     (ld_tx_en),
        .miso_i      (spi_miso_i),
        .sck_o       (spi_sck_o),
        .mosi_o      (spi_mosi_o),
        .rx_word_o   (rx_word),
        .word_done_o (word_done),
        .bit_done_o  (bit_done)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wcnt_d   = wcnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        cs_d     = cs_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        ld       = 1'b0;
        ld_nbits = '0;
        ld_tx    = '0;
        ld_tx_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                // An explicit boot request overrides the autoboot slot 0.
                if (boot_i || ((AUTOBOOT != 0) && first_q)) begin
                    addr_d   = slot_addr(SLOT_BASE, SLOT_SIZE, boot_i ? slot_i : 4'd0);
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    cs_d     = 1'b0;
                    ld       = 1'b1;
                    ld_nbits = NBITS_W'(8);
                    ld_tx    = {SPI_CMD_READ, 24'h0};
                    ld_tx_en = 1'b1;
                    state_d  = CMD;
                end
            end
            CMD: begin
                if (bit_done) begin
                    ld       = 1'b1;
                    ld_nbits = NBITS_W'(24);
                    ld_tx    = {addr_q, 8'h00};
                    ld_tx_en = 1'b1;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                if (bit_done) begin
                    ld       = 1'b1;
                    ld_nbits = NBITS_W'(WORD_BITS);
                    wcnt_d   = WCNT_W'(BITSTREAM_WORDS);
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (word_done) begin
                    data_d  = rx_word;
                    valid_d = 1'b1;
                end
                if (bit_done) begin
                    if (wcnt_q == WCNT_W'(1)) begin
                        state_d = END;
                    end else begin
                        wcnt_d   = wcnt_q - WCNT_W'(1);
                        ld       = 1'b1;
                        ld_nbits = NBITS_W'(WORD_BITS);
                    end
                end
            end
            END: begin
                cs_d    = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cs_q    <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cs_q    <= cs_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            first_q <= 1'b0;
        end
    end

    assign bitstream_data_o  = data_q;
    assign bitstream_valid_o = valid_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign spi_cs_no         = cs_q;

endmodule

// File: tb/tb_bitstream_loader.sv
// Bench for bitstream_loader: behavioural flash models, a cycle-position reference
// model for the autoboot instance, and a second instance for slot-address wrap-around.
module tb_bitstream_loader;

    localparam int W0       = 4;
    localparam int LAST_SCK = 64 + 64 * W0;
    localparam int LOAD_CYC = LAST_SCK + 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        boot0, boot1;
    logic [3:0]  slot0, slot1;
    logic        miso0, miso1;
    logic [31:0] data0, data1;
    logic        valid0, valid1, busy0, busy1, done0, done1;
    logic        sck0, sck1, cs_n0, cs_n1, mosi0, mosi1;

    always #5 clk_i = ~clk_i;

    bitstream_loader #(
        .SLOT_BASE(24'h000000), .SLOT_SIZE(24'h010000),
        .BITSTREAM_WORDS(W0), .AUTOBOOT(1)
    ) u_dut0 (
        .clk_i(clk_i), .rst_ni(rst_ni), .boot_i(boot0), .slot_i(slot0),
        .bitstream_data_o(data0), .bitstream_valid_o(valid0),
        .busy_o(busy0), .done_o(done0), .spi_sck_o(sck0), .spi_cs_no(cs_n0),
        .spi_mosi_o(mosi0), .spi_miso_i(miso0)
    );

    bitstream_loader #(
        .SLOT_BASE(24'hF80000), .SLOT_SIZE(24'h010000),
        .BITSTREAM_WORDS(1), .AUTOBOOT(0)
    ) u_dut1 (
        .clk_i(clk_i), .rst_ni(rst_ni), .boot_i(boot1), .slot_i(slot1),
        .bitstream_data_o(data1), .bitstream_valid_o(valid1),
        .busy_o(busy1), .done_o(done1), .spi_sck_o(sck1), .spi_cs_no(cs_n1),
        .spi_mosi_o(mosi1), .spi_miso_i(miso1)
    );

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'd0: return 8'hDE;
            24'd1: return 8'hAD;
            24'd2: return 8'hBE;
            24'd3: return 8'hEF;
            24'd4: return 8'h01;
            24'd5: return 8'h23;
            24'd6: return 8'h45;
            24'd7: return 8'h67;
            default: return (a[7:0] * 8'd37) ^ (a[15:8] * 8'd11) ^ (a[23:16] * 8'd5) ^ 8'h3C;
        endcase
    endfunction

    function automatic logic [31:0] flash_word(input logic [23:0] a);
        return {flash_byte(a), flash_byte(a + 24'd1), flash_byte(a + 24'd2), flash_byte(a + 24'd3)};
    endfunction

    int tests = 0;
    int failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Flash models: latch command/address on sck rise, shift data out on sck fall.
    int          f_rises, f_idx, g_rises, g_idx;
    logic [31:0] f_hdr, f_last_hdr, g_hdr, g_last_hdr;
    logic [7:0]  f_byte, g_byte;
    logic        f_prev, g_prev;

    always @(sck0 or cs_n0) begin
        if (cs_n0) begin
            f_rises = 0;
            f_hdr   = 32'h0;
            miso0   = 1'b0;
        end else if (sck0 && !f_prev) begin
            f_rises++;
            if (f_rises <= 32) f_hdr = {f_hdr[30:0], mosi0};
            if (f_rises == 32) f_last_hdr = f_hdr;
        end else if (!sck0 && f_prev && f_rises >= 32) begin
            f_idx  = f_rises - 32;
            f_byte = flash_byte(f_hdr[23:0] + 24'(f_idx / 8));
            miso0  = f_byte[7 - (f_idx % 8)];
        end
        f_prev = sck0;
    end

    always @(sck1 or cs_n1) begin
        if (cs_n1) begin
            g_rises = 0;
            g_hdr   = 32'h0;
            miso1   = 1'b0;
        end else if (sck1 && !g_prev) begin
            g_rises++;
            if (g_rises <= 32) g_hdr = {g_hdr[30:0], mosi1};
            if (g_rises == 32) g_last_hdr = g_hdr;
        end else if (!sck1 && g_prev && g_rises >= 32) begin
            g_idx  = g_rises - 32;
            g_byte = flash_byte(g_hdr[23:0] + 24'(g_idx / 8));
            miso1  = g_byte[7 - (g_idx % 8)];
        end
        g_prev = sck1;
    end

    int v1cnt = 0;
    always @(negedge clk_i) if (valid1) v1cnt++;

    // Reference model: outputs follow from the cycle position k within a cs-low window.
    bit          m_active = 1'b0;
    bit          m_first = 1'b1;
    bit          m_done = 1'b0;
    int          m_k = 0;
    logic [23:0] m_addr = 24'h0;
    logic [31:0] m_data = 32'h0;
    int          cs_cnt = 0, cs_len = 0, cs_falls = 0, vload = 0;
    logic        cs_prev = 1'b1, mosi_prev = 1'b0;

    always @(posedge clk_i) begin
        logic [31:0] hdr;
        bit          e_sck, e_mosi, e_valid;
        #1;
        if (!rst_ni) begin
            m_first  = 1'b1;
            m_active = 1'b0;
            m_k      = 0;
            m_done   = 1'b0;
            m_data   = 32'h0;
        end else begin
            if (!m_active) begin
                if (boot0 || m_first) begin
                    m_active = 1'b1;
                    m_k      = 1;
                    m_addr   = boot0 ? 24'(slot0) * 24'h010000 : 24'h0;
                    m_done   = 1'b0;
                    vload    = 0;
                end
            end else begin
                m_k++;
                if (m_k == LOAD_CYC) begin
                    m_active = 1'b0;
                    m_k      = 0;
                    m_done   = 1'b1;
                end
            end
            m_first = 1'b0;
        end
        hdr     = {8'h03, m_addr};
        e_sck   = m_active && m_k <= LAST_SCK && (m_k % 2 == 0);
        e_mosi  = m_active && m_k <= 64 && hdr[31 - (m_k - 1) / 2];
        e_valid = m_active && m_k >= 128 && m_k <= LAST_SCK && (m_k % 64 == 0);
        if (e_valid) m_data = flash_word(m_addr + 24'(4 * (m_k / 64 - 2)));
        check("cs_n", 32'(cs_n0), 32'(!m_active));
        check("busy", 32'(busy0), 32'(m_active));
        check("done", 32'(done0), 32'(m_done));
        check("sck", 32'(sck0), 32'(e_sck));
        check("mosi", 32'(mosi0), 32'(e_mosi));
        check("valid", 32'(valid0), 32'(e_valid));
        check("data", data0, m_data);
        if (mosi0 !== mosi_prev) check("mosi_change_sck_low", 32'(sck0), 32'd0);
        mosi_prev = mosi0;
        if (valid0) vload++;
        if (cs_prev && !cs_n0) cs_falls++;
        if (!cs_n0) cs_cnt++;
        else if (cs_cnt != 0) begin
            cs_len = cs_cnt;
            cs_cnt = 0;
        end
        cs_prev = cs_n0;
    end

    task automatic wait_valid0(input string name);
        int n = 0;
        while (!valid0 && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        check(name, 32'(valid0), 32'd1);
    endtask

    task automatic wait_idle0(input string name);
        int n = 0;
        while (busy0 && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        check(name, 32'(busy0), 32'd0);
    endtask

    initial begin
        int n;
        int falls_before;
        rst_ni = 1'b0;
        boot0  = 1'b0;
        slot0  = 4'd0;
        boot1  = 1'b0;
        slot1  = 4'd0;
        repeat (3) @(negedge clk_i);
        check("rst_cs_n", 32'(cs_n0), 32'd1);
        check("rst_sck", 32'(sck0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_data", data0, 32'd0);

        // Autoboot of slot 0.
        rst_ni = 1'b1;
        wait_valid0("autoboot_w0_wait");
        check("autoboot_w0", data0, 32'hDEADBEEF);
        @(negedge clk_i);
        wait_valid0("autoboot_w1_wait");
        check("autoboot_w1", data0, 32'h01234567);
        wait_idle0("autoboot_end_wait");
        check("autoboot_done", 32'(done0), 32'd1);
        check("autoboot_hdr", f_last_hdr, 32'h03000000);
        check("autoboot_cs_len", 32'(cs_len), 32'd321);
        check("autoboot_pulses", 32'(vload), 32'd4);

        // Slot 3 started one cycle after cs rises; slot 5 request mid-load is dropped.
        falls_before = cs_falls;
        boot0 = 1'b1;
        slot0 = 4'd3;
        @(negedge clk_i);
        boot0 = 1'b0;
        repeat (100) @(negedge clk_i);
        boot0 = 1'b1;
        slot0 = 4'd5;
        @(negedge clk_i);
        boot0 = 1'b0;
        wait_valid0("slot3_w0_wait");
        check("slot3_w0", data0, flash_word(24'h030000));
        wait_idle0("slot3_end_wait");
        check("slot3_hdr", f_last_hdr, 32'h03030000);
        check("slot3_cs_periods", 32'(cs_falls - falls_before), 32'd1);
        check("slot3_pulses", 32'(vload), 32'd4);

        boot0 = 1'b1;
        slot0 = 4'd7;
        @(negedge clk_i);
        boot0 = 1'b0;
        check("min_gap_cs_low", 32'(cs_n0), 32'd0);
        wait_valid0("slot7_w0_wait");
        wait_idle0("slot7_end_wait");

        // Random boot traffic, including requests while busy.
        repeat (3000) begin
            @(negedge clk_i);
            boot0 = ($urandom_range(15) == 0);
            slot0 = 4'($urandom);
        end
        @(negedge clk_i);
        boot0 = 1'b0;
        @(negedge clk_i);
        wait_idle0("random_end_wait");

        // Reset mid-DATA while sck is high.
        boot0 = 1'b1;
        slot0 = 4'd2;
        @(negedge clk_i);
        boot0 = 1'b0;
        n = 0;
        while (!(m_active && m_k == 228) && n < 500) begin
            @(negedge clk_i);
            n++;
        end
        check("rst_point_k", 32'(m_k), 32'd228);
        check("rst_point_sck", 32'(sck0), 32'd1);
        rst_ni = 1'b0;
        #1;
        check("midrst_cs_n", 32'(cs_n0), 32'd1);
        check("midrst_sck", 32'(sck0), 32'd0);
        check("midrst_mosi", 32'(mosi0), 32'd0);
        check("midrst_valid", 32'(valid0), 32'd0);
        check("midrst_busy", 32'(busy0), 32'd0);
        check("midrst_done", 32'(done0), 32'd0);
        check("midrst_data", data0, 32'd0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        wait_valid0("reload_w0_wait");
        check("reload_w0", data0, 32'hDEADBEEF);
        wait_idle0("reload_end_wait");

        // Wrap-around: 0xF80000 + 15 * 0x10000 truncates to 0x070000.
        boot1 = 1'b1;
        slot1 = 4'd15;
        @(negedge clk_i);
        boot1 = 1'b0;
        n = 0;
        while (!done1 && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        check("wrap_done", 32'(done1), 32'd1);
        check("wrap_busy", 32'(busy1), 32'd0);
        check("wrap_cs_n", 32'(cs_n1), 32'd1);
        check("wrap_hdr", g_last_hdr, 32'h03070000);
        check("wrap_w0", data1, flash_word(24'h070000));
        check("wrap_pulses", 32'(v1cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bitstream_loader.md
Name: bitstream_loader

Overview:
- Transmit end of the fabric bitstream interface.
- Fetches a configuration bitstream from an external SPI NOR flash (READ 0x03) and streams 32-bit words on a data/valid pair into the fabric configuration controller.
- Triggered automatically after reset (slot 0) and by fabric warmboot requests (boot + 4-bit slot). Its busy output drives the fabric warmboot reset.

Parameters:
- SLOT_BASE, 24'h000000, flash byte address of slot 0.
- SLOT_SIZE, 24'h010000, byte stride between slots.
- BITSTREAM_WORDS, 4096, 32-bit words streamed per load; must be ≥ 1.
- AUTOBOOT, 1, 1 = start a slot-0 load on the first cycle after reset release.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset.
- boot_i  input  1  load request, level-sampled each cycle (warmboot boot).
- slot_i  input  4  slot to load, captured in the cycle boot_i is accepted.
- bitstream_data_o  output  32  word to the configuration controller.
- bitstream_valid_o  output  1  single-cycle strobe qualifying bitstream_data_o.
- busy_o  output  1  high from acceptance of a load until cs returns high.
- done_o  output  1  sticky; set when a load completes, cleared when a new load starts.
- spi_sck_o  output  1  SPI clock, mode 0, idles low.
- spi_cs_no  output  1  flash chip select, active low.
- spi_mosi_o  output  1  command/address out, MSB first.
- spi_miso_i  input  1  data in.

Behaviour:
- Clock and reset: one clock domain (clk_i). Reset is asynchronous and active-low on rst_ni.
- Reset values: spi_cs_no=1, spi_sck_o=0, spi_mosi_o=0, bitstream_data_o=0, bitstream_valid_o=0, busy_o=0, done_o=0.
- Asserting rst_ni mid-transfer immediately forces cs high and sck low. The partial word is discarded and no valid strobe is issued.
- States: IDLE → CMD (8 bits) → ADDR (24 bits) → DATA (32 bits per word, repeated BITSTREAM_WORDS times) → END → IDLE.
- Accept: in IDLE, if boot_i=1, or on the first post-reset cycle with AUTOBOOT=1 (slot 0):
  - capture the slot;
  - compute addr = SLOT_BASE + slot*SLOT_SIZE, truncated to 24 bits (wrap-around allowed);
  - set busy_o=1, clear done_o, drive cs low in the next cycle.
- Simultaneous AUTOBOOT start and boot_i on the first cycle: boot_i wins and its slot is used.
- boot_i while busy is ignored. There is no queueing; the request must be re-asserted after busy_o falls.
- Bit timing: every bit takes 2 clk cycles.
  - Phase 0: sck=0, MOSI updated.
  - Phase 1: sck=1.
  - MISO is sampled on the clk edge that raises sck.
  - SCK = clk/2.
- First sck rise occurs on the 2nd cycle after cs falls. The command byte is 8'h03, followed by addr[23:0].
- DATA: bits shift in MSB first. The first flash byte lands in [31:24].
- After the 32nd bit, bitstream_data_o is updated and bitstream_valid_o pulses for exactly 1 cycle (the cycle after the 32nd sample). data_o holds until the next word.
- Consecutive valid pulses are exactly 64 cycles apart. The next word shifts without a gap, and cs stays low for the whole burst.
- Word counter: width $clog2(BITSTREAM_WORDS+1). A load terminates after exactly BITSTREAM_WORDS valid pulses.
- END: 1 cycle, sck low, then cs high. busy_o falls and done_o=1 in the same cycle cs rises.
- Minimum cs-high time before the next load: 1 cycle.
- MOSI during DATA is 0.

Decomposition:
- Package fabric_loader_pkg:
  - SPI_CMD_READ = 8'h03;
  - loader_state_t enum {IDLE, CMD, ADDR, DATA, END};
  - WORD_BITS = 32.
- Sub-module spi_shifter:
  - owns sck/mosi generation and the 32-bit shift register;
  - interface: load strobe, nbits, tx word, bit_done/word_done.
- bitstream_loader owns the FSM, slot address arithmetic, word counter and status flags.

Test Plan:
- AUTOBOOT=1, BITSTREAM_WORDS=4, flash model with slot 0 = 32'hDEADBEEF, 32'h01234567, … → MOSI shows 0x03 then 0x000000; 4 valid pulses 64 cycles apart with matching data; done_o=1 and busy_o=0 after cs rises.
- Slot addressing: boot_i=1, slot_i=4'd3 → address 0x030000 on MOSI; first word equals the flash content at 0x030000.
- Wrap-around: SLOT_BASE=24'hF80000, slot 15 → address 24'h070000 (truncated).
- boot_i pulsed mid-load with slot 5 → ignored; exactly BITSTREAM_WORDS pulses from the original slot; no second cs-low period.
- Reset mid-DATA (rst_ni low after bit 17 of word 2) → cs high and sck low in the same cycle, no valid pulse, all outputs at reset values; reload after release starts from word 0.
- Mode-0 timing check: assert MISO changes only while sck low and sampling on sck rise; cs low spans exactly 2*(32+32*BITSTREAM_WORDS)+1 cycles.
